// File: rtl/data_sram_pkg.sv
// Shared definitions for the data SRAM responder: FSM states, default
// geometry and the byte-lane write-enable patterns used by EX.
package data_sram_pkg;

  // Clear sequencer states
  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } sram_state_e;

  localparam int DEPTH_DEFAULT = 1024;
  localparam int WORD_BYTES    = 4;

  localparam logic [3:0] WEN_WORD    = 4'b1111;
  localparam logic [3:0] WEN_HALF_LO = 4'b0011;
  localparam logic [3:0] WEN_HALF_HI = 4'b1100;

endpackage

// File: rtl/data_sram_resp_if.sv
// Data SRAM port bundle between the EX stage (master) and the memory
// responder (slave). Parity signals exist only with DATA_SRAM_PARITY_EN.
interface data_sram_resp_if;
  import data_sram_pkg::*;

  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
`ifdef DATA_SRAM_PARITY_EN
  logic        parity_inject;
  logic        parity_err;

  modport master (
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata, parity_inject,
    input  data_sram_rdata, parity_err
  );
  modport slave (
    input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata, parity_inject,
    output data_sram_rdata, parity_err
  );
`else
  modport master (
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    input  data_sram_rdata
  );
  modport slave (
    input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    output data_sram_rdata
  );
`endif

endinterface

// File: rtl/data_sram_resp_byte_parity4.sv
// Per-byte even parity of a 32-bit word: bit i is the XOR of byte i, so the
// byte plus its parity bit always holds an even number of ones.
module byte_parity4
  import data_sram_pkg::*;
(
  input  logic [31:0] data_i,
  output logic [3:0]  par_o
);

  for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_par
    assign par_o[gi] = ^data_i[8*gi +: 8];
  end

endmodule

// File: rtl/data_sram_resp.sv
// Data SRAM responder: word-organised single-port memory with byte-lane
// writes, one-cycle registered read data and a post-reset clear sequencer
// that zeroes every word before accesses are accepted. Out-of-range and
// busy-time accesses are recorded in sticky flags.
// Optional feature macro: DATA_SRAM_PARITY_EN (per-byte stored parity).
module data_sram_resp
  import data_sram_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  data_sram_resp_if.slave   bus,
  output logic              busy,
  output logic              oob_err,
  output logic [31:0]       err_addr,
  output logic              drop_err
);

  sram_state_e state_q, state_d;
  logic [AW-1:0] clr_idx_q, clr_idx_d;

  logic          in_range;
  logic [AW-1:0] acc_idx;
  logic          clearing;
  logic          acc_ok;
  logic          acc_wr;
  logic          rd_en;
  logic [AW-1:0] wr_idx;
  logic [31:0]   rdata_w;
  logic          oob_err_q;
  logic          drop_err_q;
  logic [31:0]   err_addr_q;
  logic          unused_addr_lsb;

  // addr[1:0] selects a byte within the word and plays no part in the access
  assign unused_addr_lsb = ^bus.data_sram_addr[1:0];

  assign acc_idx  = bus.data_sram_addr[AW+1:2];
  assign in_range = (bus.data_sram_addr[31:AW+2] == '0);

  // A cycle with rst high never touches memory, so a write racing reset is lost
  assign clearing = !rst && (state_q == CLEAR);
  assign acc_ok   = !rst && bus.data_sram_en && (state_q == READY);
  assign acc_wr   = acc_ok && in_range && (bus.data_sram_wen != 4'b0000);
  assign rd_en    = acc_ok && (bus.data_sram_wen == 4'b0000);
  assign wr_idx   = clearing ? clr_idx_q : acc_idx;

  // Clear sequencer next state: sweep every index once, then serve forever
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    if (state_q == CLEAR) begin
      clr_idx_d = clr_idx_q + 1'b1;
      if (clr_idx_q == AW'(DEPTH - 1)) begin
        state_d = READY;
      end
    end
  end

  // Clear sequencer state register; reset restarts the sweep from index 0
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

`ifdef DATA_SRAM_PARITY_EN
  logic [3:0] wr_par;
  logic [3:0] rd_par_calc;
  logic [3:0] rd_par_w;

  byte_parity4 u_wr_par (.data_i(bus.data_sram_wdata), .par_o(wr_par));
  byte_parity4 u_rd_par (.data_i(rdata_w),             .par_o(rd_par_calc));
`endif

  // One independent byte-wide memory per lane keeps lane writes simple RAM writes
  for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
    logic [7:0] mem_array [DEPTH];
    logic [7:0] rd_byte_q;
    logic       lane_we;
    logic [7:0] wr_byte;

    assign lane_we = clearing || (acc_wr && bus.data_sram_wen[gi]);
    assign wr_byte = clearing ? 8'h00 : bus.data_sram_wdata[8*gi +: 8];

    // Lane write port: clear sweep or byte-enabled store
    always_ff @(posedge clk) begin
      if (lane_we) begin
        mem_array[wr_idx] <= wr_byte;
      end
    end

    // Lane read register: loads on reads only, out-of-range reads return zero
    always_ff @(posedge clk) begin
      if (rst) begin
        rd_byte_q <= 8'h00;
      end else if (rd_en) begin
        rd_byte_q <= in_range ? mem_array[acc_idx] : 8'h00;
      end
    end

    assign rdata_w[8*gi +: 8] = rd_byte_q;

`ifdef DATA_SRAM_PARITY_EN
    logic par_array [DEPTH];
    logic rd_par_q;
    logic par_bit;

    assign par_bit = clearing ? 1'b0 : (wr_par[gi] ^ bus.parity_inject);

    // Stored parity bit travels with its lane's data
    always_ff @(posedge clk) begin
      if (lane_we) begin
        par_array[wr_idx] <= par_bit;
      end
    end

    // Stored parity is registered with the read byte so both hold together
    always_ff @(posedge clk) begin
      if (rst) begin
        rd_par_q <= 1'b0;
      end else if (rd_en) begin
        rd_par_q <= in_range ? par_array[acc_idx] : 1'b0;
      end
    end

    assign rd_par_w[gi] = rd_par_q;
`endif
  end

  assign bus.data_sram_rdata = rdata_w;

`ifdef DATA_SRAM_PARITY_EN
  // Only registered values feed this, so it is stable for as long as rdata is
  assign bus.parity_err = |(rd_par_calc ^ rd_par_w);
`endif

  // Sticky error flags; err_addr keeps the first out-of-range address only
  always_ff @(posedge clk) begin
    if (rst) begin
      oob_err_q  <= 1'b0;
      drop_err_q <= 1'b0;
      err_addr_q <= 32'h0;
    end else if (bus.data_sram_en) begin
      if (state_q == CLEAR) begin
        drop_err_q <= 1'b1;
      end else if (!in_range) begin
        oob_err_q <= 1'b1;
        if (!oob_err_q) begin
          err_addr_q <= bus.data_sram_addr;
        end
      end
    end
  end

  assign busy     = (state_q == CLEAR);
  assign oob_err  = oob_err_q;
  assign drop_err = drop_err_q;
  assign err_addr = err_addr_q;

endmodule

// File: tb/tb_data_sram_resp.sv
// Bench for data_sram_resp: directed scenarios with literal expectations,
// then random traffic, all compared every cycle against a behavioural model
// (clear counter, word array, per-lane "parity corrupted" bits).
module tb_data_sram_resp;
  import data_sram_pkg::*;

  localparam int DEPTH = 1024;

  logic        clk;
  logic        rst;
  logic        dut_busy;
  logic        dut_oob_err;
  logic [31:0] dut_err_addr;
  logic        dut_drop_err;

  data_sram_resp_if bus ();

  data_sram_resp #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .busy     (dut_busy),
    .oob_err  (dut_oob_err),
    .err_addr (dut_err_addr),
    .drop_err (dut_drop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem [DEPTH];
  logic [3:0]  m_bad [DEPTH];
  int          m_clr_cnt;
  logic        m_valid = 1'b0;
  logic [31:0] m_rdata;
  logic        m_par;
  logic        m_oob;
  logic        m_drop;
  logic [31:0] m_eaddr;

  always @(posedge clk) begin
    logic        inj;
    int          idx;
`ifdef DATA_SRAM_PARITY_EN
    inj = bus.parity_inject;
`else
    inj = 1'b0;
`endif
    if (rst) begin
      m_valid   = 1'b1;
      m_clr_cnt = 0;
      m_rdata   = 32'h0;
      m_par     = 1'b0;
      m_oob     = 1'b0;
      m_drop    = 1'b0;
      m_eaddr   = 32'h0;
      for (int i = 0; i < DEPTH; i++) begin
        m_mem[i] = 32'h0;
        m_bad[i] = 4'h0;
      end
    end else if (m_valid) begin
      if (m_clr_cnt < DEPTH) begin
        m_clr_cnt++;
        if (bus.data_sram_en) m_drop = 1'b1;
      end else if (bus.data_sram_en) begin
        if (bus.data_sram_addr >= 32'(DEPTH * 4)) begin
          if (!m_oob) m_eaddr = bus.data_sram_addr;
          m_oob = 1'b1;
          if (bus.data_sram_wen == 4'b0000) begin
            m_rdata = 32'h0;
            m_par   = 1'b0;
          end
        end else begin
          idx = int'(bus.data_sram_addr) / 4;
          if (bus.data_sram_wen == 4'b0000) begin
            m_rdata = m_mem[idx];
            m_par   = |m_bad[idx];
          end else begin
            for (int b = 0; b < 4; b++) begin
              if (bus.data_sram_wen[b]) begin
                m_mem[idx][8*b +: 8] = bus.data_sram_wdata[8*b +: 8];
                m_bad[idx][b]        = inj;
              end
            end
          end
        end
      end
    end
  end

  // Per-cycle comparison of every DUT output with the model
  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy",     {31'h0, dut_busy},     {31'h0, (m_clr_cnt < DEPTH)});
      chk("rdata",    bus.data_sram_rdata,   m_rdata);
      chk("oob_err",  {31'h0, dut_oob_err},  {31'h0, m_oob});
      chk("drop_err", {31'h0, dut_drop_err}, {31'h0, m_drop});
      chk("err_addr", dut_err_addr,          m_eaddr);
`ifdef DATA_SRAM_PARITY_EN
      chk("parity_err", {31'h0, bus.parity_err}, {31'h0, m_par});
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive_idle();
    bus.data_sram_en    = 1'b0;
    bus.data_sram_wen   = 4'b0000;
    bus.data_sram_addr  = 32'h0;
    bus.data_sram_wdata = 32'h0;
`ifdef DATA_SRAM_PARITY_EN
    bus.parity_inject   = 1'b0;
`endif
  endtask

  // One access in a single cycle; returns at the next negedge with results visible
  task automatic acc(input logic [3:0] wen, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic inj);
    bus.data_sram_en    = 1'b1;
    bus.data_sram_wen   = wen;
    bus.data_sram_addr  = addr;
    bus.data_sram_wdata = wdata;
`ifdef DATA_SRAM_PARITY_EN
    bus.parity_inject   = inj;
`else
    if (inj) $display("note: parity_inject ignored in this build");
`endif
    @(negedge clk);
    drive_idle();
  endtask

  // Counts cycles with busy high from the reset-release negedge; optional
  // read of 0x10 in cycle drop_at. Bounded so a stuck busy cannot hang.
  task automatic count_busy(input int drop_at, output int n);
    n = 0;
    while (dut_busy && n < 3 * DEPTH) begin
      bus.data_sram_en   = (n == drop_at);
      bus.data_sram_wen  = 4'b0000;
      bus.data_sram_addr = 32'h10;
      n++;
      @(negedge clk);
    end
    drive_idle();
  endtask

  int n_busy;

  initial begin
    drive_idle();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Clear duration and drop during clear
    count_busy(5, n_busy);
    chk("clear_cycles", n_busy, DEPTH);
    chk("drop_set", {31'h0, dut_drop_err}, 32'h1);
    acc(4'b0000, 32'h10, 32'h0, 1'b0);
    chk("read_after_clear", bus.data_sram_rdata, 32'h0);

    // Byte-lane merging
    acc(WEN_WORD, 32'h20, 32'hDEADBEEF, 1'b0);
    acc(4'b0001,  32'h20, 32'h000000AA, 1'b0);
    acc(4'b0000,  32'h20, 32'h0, 1'b0);
    chk("lane_merge", bus.data_sram_rdata, 32'hDEADBEAA);
    chk("model_lane_merge", m_rdata, 32'hDEADBEAA);
    acc(WEN_HALF_HI, 32'h20, 32'h12340000, 1'b0);
    acc(4'b0000,     32'h20, 32'h0, 1'b0);
    chk("half_hi", bus.data_sram_rdata, 32'h1234BEAA);
    chk("model_half_hi", m_rdata, 32'h1234BEAA);

    // Hold on idle, then neighbouring word
    acc(4'b0000, 32'h20, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_hold", bus.data_sram_rdata, 32'h1234BEAA);
    end
    acc(4'b0000, 32'h24, 32'h0, 1'b0);
    chk("neighbour_zero", bus.data_sram_rdata, 32'h0);

    // Out-of-range accesses
    acc(4'b0000, 32'h00001000, 32'h0, 1'b0);
    chk("oob_set", {31'h0, dut_oob_err}, 32'h1);
    chk("oob_rdata", bus.data_sram_rdata, 32'h0);
    acc(WEN_WORD, 32'h00002000, 32'hCAFEF00D, 1'b0);
    chk("err_addr_first", dut_err_addr, 32'h00001000);
    chk("model_err_addr", m_eaddr, 32'h00001000);
    acc(4'b0000, 32'h0, 32'h0, 1'b0);
    chk("word0_untouched", bus.data_sram_rdata, 32'h0);

    // Reset mid-operation, then again mid-clear at index 100
    acc(WEN_WORD, 32'h40, 32'h55AA55AA, 1'b0);
    acc(WEN_HALF_LO, 32'h44, 32'h00007777, 1'b0);
    acc(4'b0000, 32'h40, 32'h0, 1'b0);
    chk("pre_reset_word", bus.data_sram_rdata, 32'h55AA55AA);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("oob_cleared", {31'h0, dut_oob_err}, 32'h0);
    repeat (100) @(negedge clk);
    rst = 1'b1;
    bus.data_sram_en = 1'b1;
    bus.data_sram_wen = WEN_WORD;
    bus.data_sram_addr = 32'h48;
    bus.data_sram_wdata = 32'hFFFFFFFF;
    @(negedge clk);
    drive_idle();
    rst = 1'b0;
    count_busy(-1, n_busy);
    chk("clear_cycles_again", n_busy, DEPTH);
    acc(4'b0000, 32'h40, 32'h0, 1'b0);
    chk("word_cleared", bus.data_sram_rdata, 32'h0);
    acc(4'b0000, 32'h48, 32'h0, 1'b0);
    chk("write_in_reset_lost", bus.data_sram_rdata, 32'h0);

`ifdef DATA_SRAM_PARITY_EN
    acc(WEN_WORD, 32'h80, 32'hFF00FF00, 1'b1);
    acc(4'b0000,  32'h80, 32'h0, 1'b0);
    chk("parity_injected", {31'h0, bus.parity_err}, 32'h1);
    acc(WEN_WORD, 32'h80, 32'hFF00FF00, 1'b0);
    acc(4'b0000,  32'h80, 32'h0, 1'b0);
    chk("parity_clean", {31'h0, bus.parity_err}, 32'h0);
`endif

    // Random traffic in a small window plus occasional out-of-range addresses
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a;
      a = {22'h0, 4'h0, 6'($urandom_range(0, 63)) ^ 6'h0, 2'($urandom)} ;
      a = 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) a = 32'(DEPTH * 4) + $urandom_range(0, 4095);
      bus.data_sram_en    = ($urandom_range(0, 3) != 0);
      bus.data_sram_wen   = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
      bus.data_sram_addr  = a;
      bus.data_sram_wdata = $urandom;
`ifdef DATA_SRAM_PARITY_EN
      bus.parity_inject   = ($urandom_range(0, 7) == 0);
`endif
      @(negedge clk);
    end
    drive_idle();
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/data_sram_resp.md
# data_sram_resp

Responder side of the data SRAM port that the EX stage drives (en / byte-lane wen / addr / wdata). It is a single-port, word-organised synchronous memory with byte-lane writes, 1-cycle registered read data and a post-reset clear sequencer. It records out-of-range and dropped accesses. It sits in the top-level SoC and the bench in place of the external data RAM, and feeds data_sram_rdata to MEM/WB.

## Interface
Parameters:
- DEPTH, 1024: number of 32-bit words; power of two, ≥ 4.
- AW, $clog2(DEPTH): word-index width.

Ports:
- clk  in  1  sole clock; everything is rising-edge.
- rst  in  1  reset; synchronous and active-high.
- data_sram_en  in  1  access request this cycle.
- data_sram_wen  in  4  byte-lane write enables; bit i covers wdata[8i+7:8i]; 0000 means read.
- data_sram_addr  in  32  byte address; word index = addr[AW+1:2]; addr[1:0] is ignored.
- data_sram_wdata  in  32  write data, already lane-aligned by EX.
- data_sram_rdata  out  32  read data, registered.
- busy  out  1  clear sequence in progress; accesses are dropped.
- oob_err  out  1  sticky flag: an access had addr ≥ DEPTH*4.
- err_addr  out  32  address of the first out-of-range access since reset.
- drop_err  out  1  sticky flag: an access arrived while busy.
- parity_inject  in  1  (DATA_SRAM_PARITY_EN only) invert stored parity for the lanes written this cycle.
- parity_err  out  1  (DATA_SRAM_PARITY_EN only) parity mismatch on the current rdata.

## Operation
- FSM states: CLEAR, READY.
  - While rst=1: state=CLEAR, clear_idx=0, busy=1, rdata=0, oob_err=0, drop_err=0, err_addr=0, parity_err=0.
  - CLEAR: writes zero to word clear_idx (and zero parity) each cycle, then increments clear_idx. When clear_idx=DEPTH-1 is written, the next state is READY.
  - READY: serves accesses. There is no exit except rst.
- Write (READY, en=1, wen≠0, in range): only the lanes with wen[i]=1 are updated; the other bytes keep their value. rdata does not change.
- Read (READY, en=1, wen=0, in range): rdata ← mem[idx] at the edge.
- Idle (en=0): rdata holds its last value.
- Out-of-range access (addr[31:AW+2]≠0), read or write:
  - No memory update.
  - On a read, rdata ← 0.
  - oob_err is set. err_addr is captured only if oob_err was 0.
- Access while busy: dropped; drop_err is set; rdata is unchanged.
- Sticky flags clear only on rst.

## Timing
- Read latency is 1: request at edge N, data visible after edge N and valid through the cycle after it, until the next read.
- Write at edge N followed by a read at edge N+1 of the same word returns the new data. Back-to-back reads are full throughput.
- Clear takes exactly DEPTH cycles after the first cycle with rst=0. busy falls in cycle DEPTH, so the first accepted access is in cycle DEPTH.
- rst asserted mid-clear or mid-operation restarts CLEAR from index 0 on the next edge. A write issued in the same cycle as rst is discarded.
- oob_err and drop_err rise at the edge that samples the offending access.

## Configuration
- Macro DATA_SRAM_PARITY_EN.
- Defined:
  - Each word stores 4 even-parity bits, one per byte, written with the lane data (inverted when parity_inject=1).
  - A read recomputes parity on the stored data. parity_err is registered alongside rdata: it is 1 for a mismatched read and holds with rdata.
  - Out-of-range reads give parity_err=0.
- Undefined: no parity storage; the parity_inject and parity_err ports are absent.

## Structure
- Shared package data_sram_pkg holds:
  - the state enum (CLEAR, READY);
  - the DEPTH default;
  - the WORD_BYTES=4 constant;
  - the lane-mask constants WEN_WORD=1111, WEN_HALF_LO=0011, WEN_HALF_HI=1100.
- Sub-module byte_parity4: combinational, 32-bit in, 4-bit per-byte even parity out. It is used on both the write and read paths, and only when the macro is defined.

## Test plan
- Reset for 3 cycles, then release → busy=1 for exactly DEPTH cycles; a read of address 0x10 issued in cycle 5 is dropped and sets drop_err=1. A read of 0x10 after busy falls returns 0x00000000.
- Write 0xDEADBEEF with wen=1111 at 0x20, then write 0x000000AA with wen=0001 at 0x20, then read 0x20 → rdata=0xDEADBEAA one cycle later. Then write 0x12340000 with wen=1100 at 0x20 and read → 0x1234BEAA.
- Read 0x20, then hold en=0 for 5 cycles → rdata stays 0x1234BEAA. A read of 0x24 in the next cycle returns 0x00000000.
- Read 0x00001000 with DEPTH=1024, then write 0x00002000 → oob_err=1, err_addr=0x00001000 (not updated by the second access), rdata=0; word 0 is unchanged.
- Assert rst for 1 cycle at clear_idx=100, then release → busy stays high for the full DEPTH cycles again. A word written before the reset reads back 0.
- With DATA_SRAM_PARITY_EN: write 0xFF00FF00 with wen=1111 and parity_inject=1, then read → parity_err=1. Rewrite with parity_inject=0 and read → parity_err=0.
